// File: rtl/conv_pkg.sv
// Shared types and helpers for the 3x3 convolution datapath.
// Holds the MAC FSM state type, accumulator width rule and weight index map.
package conv_pkg;

   typedef enum logic {
      LOAD_W,
      RUN
   } state_e;

   localparam int Taps = 9;

   // Widest possible sum of 9*d signed dw x dw products.
   function automatic int acc_width(input int dw, input int d);
      return 2 * dw + $clog2(Taps * d);
   endfunction

   // c = channel, r = row 0..2, k = column age (0 oldest, 2 current).
   function automatic int widx(input int c, input int r, input int k);
      return c * Taps + r * 3 + k;
   endfunction

endpackage

// File: rtl/conv3x3_channel_mac_mac9.sv
// mac9: nine signed multiplies with a product register, then an adder tree.
// Ports: clk, rst (sync, high), en (capture), px/wt (9 packed taps), sum.
module mac9 #(
   parameter int DataWidth = 16,
   parameter int SumWidth  = 2 * DataWidth + 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       en,
   input  logic [9*DataWidth-1:0]     px,
   input  logic [9*DataWidth-1:0]     wt,
   output logic signed [SumWidth-1:0] sum
);

   localparam int PW = 2 * DataWidth;

   logic signed [PW-1:0] prod [9];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 9; i++) begin
            prod[i] <= '0;
         end
      end else if (en) begin
         for (int i = 0; i < 9; i++) begin
            prod[i] <=
               PW'($signed(px[i*DataWidth +: DataWidth])) *
               PW'($signed(wt[i*DataWidth +: DataWidth]));
         end
      end
   end

   always_comb begin
      sum = '0;
      for (int i = 0; i < 9; i++) begin
         sum = sum + SumWidth'(prod[i]);
      end
   end

endmodule

// File: rtl/conv3x3_channel_mac.sv
// conv3x3_channel_mac: 3x3 window MAC summed over D channels per column.
// Ports: i_clk, i_rst (sync, high); i_w_data/i_w_valid load 9*D weights;
// i_col_data/i_col_valid/o_col_ready/i_row_end carry column beats, one
// channel per beat; o_data/o_valid give one result per full window.
// Build option: define CONV_RELU_EN to clamp negative results to zero.
module conv3x3_channel_mac
   import conv_pkg::*;
#(
   parameter int D         = 1,
   parameter int DataWidth = 16,
   parameter int AccWidth  = acc_width(DataWidth, D)
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic [DataWidth-1:0]       i_w_data,
   input  logic                       i_w_valid,
   input  logic [3*DataWidth-1:0]     i_col_data,
   input  logic                       i_col_valid,
   output logic                       o_col_ready,
   input  logic                       i_row_end,
   output logic signed [AccWidth-1:0] o_data,
   output logic                       o_valid
);

   localparam int NW  = Taps * D;
   localparam int WCW = $clog2(NW);
   localparam int CW  = (D > 1) ? $clog2(D) : 1;
   localparam int SW  = 2 * DataWidth + 4;

   state_e state_q, state_d;
   logic   w_we;

   logic [WCW-1:0] w_cnt;
   logic [CW-1:0]  ch_cnt;
   logic [1:0]     col_cnt;

   logic [DataWidth-1:0]   w_mem [NW];
   logic [3*DataWidth-1:0] hist0 [D];
   logic [3*DataWidth-1:0] hist1 [D];

   logic accept, last_ch, issue;

   logic [9*DataWidth-1:0] px, wt;
   logic signed [SW-1:0]   sum;

   logic beat_q, first_q, issue_q, issue_q2;
   logic signed [AccWidth-1:0] acc;

   always_comb begin
      state_d     = state_q;
      w_we        = 1'b0;
      o_col_ready = 1'b0;
      unique case (state_q)
         LOAD_W: begin
            w_we = i_w_valid;
            if (i_w_valid && w_cnt == WCW'(NW - 1)) begin
               state_d = RUN;
            end
         end
         RUN: o_col_ready = 1'b1;
         default: state_d = LOAD_W;
      endcase
   end

   assign accept  = i_col_valid && o_col_ready;
   assign last_ch = ch_cnt == CW'(D - 1);
   assign issue   = accept && last_ch && col_cnt == 2'd2;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= LOAD_W;
         w_cnt   <= '0;
         ch_cnt  <= '0;
         col_cnt <= '0;
      end else begin
         state_q <= state_d;
         if (w_we) begin
            w_cnt <= w_cnt + 1'b1;
         end
         if (accept) begin
            ch_cnt <= last_ch ? '0 : ch_cnt + 1'b1;
            if (last_ch) begin
               // Row end drops the stale history by zeroing col_cnt.
               if (i_row_end) begin
                  col_cnt <= '0;
               end else if (col_cnt != 2'd2) begin
                  col_cnt <= col_cnt + 1'b1;
               end
            end
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_we) begin
         w_mem[w_cnt] <= i_w_data;
      end
      if (accept) begin
         hist1[ch_cnt] <= hist0[ch_cnt];
         hist0[ch_cnt] <= i_col_data;
      end
   end

   // Tap t = r*3 + k, k = column age; the current column is age 2.
   always_comb begin
      px = '0;
      wt = '0;
      for (int r = 0; r < 3; r++) begin
         px[(r*3+0)*DataWidth +: DataWidth] =
            hist1[ch_cnt][r*DataWidth +: DataWidth];
         px[(r*3+1)*DataWidth +: DataWidth] =
            hist0[ch_cnt][r*DataWidth +: DataWidth];
         px[(r*3+2)*DataWidth +: DataWidth] =
            i_col_data[r*DataWidth +: DataWidth];
      end
      for (int t = 0; t < 9; t++) begin
         wt[t*DataWidth +: DataWidth] =
            w_mem[WCW'(widx(int'(ch_cnt), t / 3, t % 3))];
      end
   end

   mac9 #(
      .DataWidth(DataWidth),
      .SumWidth (SW)
   ) u_mac9 (
      .clk(i_clk),
      .rst(i_rst),
      .en (accept),
      .px (px),
      .wt (wt),
      .sum(sum)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         beat_q   <= 1'b0;
         first_q  <= 1'b0;
         issue_q  <= 1'b0;
         issue_q2 <= 1'b0;
         acc      <= '0;
         o_valid  <= 1'b0;
         o_data   <= '0;
      end else begin
         beat_q   <= accept;
         first_q  <= ch_cnt == '0;
         issue_q  <= issue;
         issue_q2 <= issue_q;
         if (beat_q) begin
            acc <= first_q ? AccWidth'(sum)
                           : acc + AccWidth'(sum);
         end
         o_valid <= issue_q2;
`ifdef CONV_RELU_EN
         if (issue_q2) begin
            o_data <= acc[AccWidth-1] ? '0 : acc;
         end
`else
         if (issue_q2) begin
            o_data <= acc;
         end
`endif
      end
   end

endmodule

// File: tb/tb_conv3x3_channel_mac.sv
// Bench for conv3x3_channel_mac (D=2): directed scenarios plus random
// beats, checked every cycle against a row-buffer window model.
module tb_conv3x3_channel_mac;

   localparam int D  = 2;
   localparam int DW = 16;
   localparam int AW = 2 * DW + $clog2(9 * D);
   localparam int NW = 9 * D;

   logic          clk = 1'b0;
   logic          rst;
   logic [DW-1:0] w_data;
   logic          w_valid;
   logic [3*DW-1:0] col_data;
   logic          col_valid;
   logic          row_end;
   logic          col_ready;
   logic [AW-1:0] data;
   logic          valid;

   int vecs = 0;
   int errs = 0;
   int cyc  = 0;

   longint wts [NW];
   longint pix [D][64][3];
   int     chn;
   int     colnum;
   bit     exp_ready;
   logic [AW-1:0] hold;
   longint exp_d [int];

   always #5 clk = ~clk;

   conv3x3_channel_mac #(
      .D        (D),
      .DataWidth(DW)
   ) dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_w_data   (w_data),
      .i_w_valid  (w_valid),
      .i_col_data (col_data),
      .i_col_valid(col_valid),
      .o_col_ready(col_ready),
      .i_row_end  (row_end),
      .o_data     (data),
      .o_valid    (valid)
   );

   task automatic chk(input string tag,
                      input logic [AW-1:0] obs,
                      input logic [AW-1:0] expv);
      vecs++;
      assert (obs === expv) else begin
         errs++;
         $error("FAIL %s observed=%0d expected=%0d",
                tag, obs, expv);
      end
   endtask

   task automatic step();
      bit due;
      @(posedge clk);
      cyc++;
      #1;
      due = exp_d.exists(cyc) != 0;
      if (due) hold = AW'(exp_d[cyc]);
      chk("o_valid", AW'(valid), AW'(due));
      chk("o_data", data, hold);
      chk("o_col_ready", AW'(col_ready), AW'(exp_ready));
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      col_valid = 1'b0;
      w_valid   = 1'b0;
      row_end   = 1'b0;
      exp_d.delete();
      hold      = '0;
      exp_ready = 1'b0;
      chn       = 0;
      colnum    = 0;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic load_w();
      for (int i = 0; i < NW; i++) begin
         if (i == 4) begin
            w_valid = 1'b0;
            step();
         end
         w_valid   = 1'b1;
         w_data    = DW'(wts[i]);
         col_valid = 1'(i);
         col_data  = {DW'($urandom), DW'($urandom), DW'($urandom)};
         if (i == NW - 1) exp_ready = 1'b1;
         step();
      end
      w_valid   = 1'b0;
      col_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         col_valid = 1'b0;
         row_end   = 1'b0;
         w_valid   = exp_ready ? 1'($urandom) : 1'b0;
         w_data    = DW'($urandom);
         step();
      end
      w_valid = 1'b0;
   endtask

   task automatic beat(input logic [DW-1:0] t,
                       input logic [DW-1:0] m,
                       input logic [DW-1:0] b,
                       input bit re);
      longint s;
      col_valid = 1'b1;
      col_data  = {b, m, t};
      row_end   = re;
      w_valid   = 1'($urandom);
      w_data    = DW'($urandom);
      pix[chn][colnum % 64][0] = longint'($signed(t));
      pix[chn][colnum % 64][1] = longint'($signed(m));
      pix[chn][colnum % 64][2] = longint'($signed(b));
      if (chn == D - 1) begin
         if (colnum >= 2) begin
            s = 0;
            for (int c = 0; c < D; c++)
               for (int r = 0; r < 3; r++)
                  for (int k = 0; k < 3; k++)
                     s += wts[c*9 + r*3 + k] *
                          pix[c][(colnum - 2 + k) % 64][r];
`ifdef CONV_RELU_EN
            if (s < 0) s = 0;
`endif
            exp_d[cyc + 3] = s;
         end
         colnum = re ? 0 : colnum + 1;
      end
      chn = (chn + 1) % D;
      step();
      col_valid = 1'b0;
      row_end   = 1'b0;
      w_valid   = 1'b0;
   endtask

   task automatic rand_w();
      for (int i = 0; i < NW; i++)
         wts[i] = longint'($signed(DW'($urandom)));
   endtask

   function automatic logic [DW-1:0] rv();
      return DW'($urandom);
   endfunction

   initial begin
      rst       = 1'b1;
      w_data    = '0;
      w_valid   = 1'b0;
      col_data  = '0;
      col_valid = 1'b0;
      row_end   = 1'b0;
      hold      = '0;
      exp_ready = 1'b0;

      // Reset state, idle in LOAD_W.
      do_reset();
      idle(5);

      // Channel 0 all ones, channel 1 zero: 18 then 27.
      for (int i = 0; i < NW; i++) wts[i] = (i < 9) ? 1 : 0;
      load_w();
      for (int v = 1; v <= 4; v++) begin
         beat(DW'(v), DW'(v), DW'(v), 1'b0);
         beat(rv(), rv(), rv(), 1'b0);
      end
      idle(4);
      chk("ones_last", data, AW'(27));

      // +1 / -1 kernels on identical channel data cancel.
      do_reset();
      for (int i = 0; i < NW; i++) wts[i] = (i < 9) ? 1 : -1;
      load_w();
      for (int j = 0; j < 6; j++) begin
         logic [DW-1:0] a, m, b;
         a = rv(); m = rv(); b = rv();
         beat(a, m, b, 1'b0);
         beat(a, m, b, 1'b0);
      end
      idle(4);
      chk("cancel", data, '0);

      // Row end on the 3rd column, stray row_end on channel 0.
      do_reset();
      rand_w();
      load_w();
      for (int j = 0; j < 3; j++) begin
         beat(rv(), rv(), rv(), 1'b1);
         beat(rv(), rv(), rv(), j == 2);
      end
      for (int j = 0; j < 4; j++) begin
         beat(rv(), rv(), rv(), 1'b0);
         beat(rv(), rv(), rv(), 1'b0);
      end
      idle(4);

      // Single tap of -7 on unit data.
      do_reset();
      for (int i = 0; i < NW; i++) wts[i] = 0;
      wts[0] = -7;
      load_w();
      for (int j = 0; j < 3; j++) begin
         beat(DW'(1), DW'(1), DW'(1), 1'b0);
         beat(DW'(1), DW'(1), DW'(1), 1'b0);
      end
      idle(4);
`ifdef CONV_RELU_EN
      chk("neg7", data, '0);
`else
      chk("neg7", data, AW'(-7));
`endif

      // Reset between channel beats of an issuing column.
      do_reset();
      rand_w();
      load_w();
      for (int j = 0; j < 2; j++) begin
         beat(rv(), rv(), rv(), 1'b0);
         beat(rv(), rv(), rv(), 1'b0);
      end
      beat(rv(), rv(), rv(), 1'b0);
      do_reset();
      idle(5);

      // Reset right after an issuing beat flushes the pipeline.
      load_w();
      for (int j = 0; j < 3; j++) begin
         beat(rv(), rv(), rv(), 1'b0);
         beat(rv(), rv(), rv(), 1'b0);
      end
      do_reset();
      idle(5);

      // Random beats, gaps and row ends.
      load_w();
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 3) == 0)
            idle(1);
         else
            beat(rv(), rv(), rv(), $urandom_range(0, 7) == 0);
      end
      idle(6);

      $display("== %0d vectors applied, %0d miscompares ==",
               vecs, errs);
      $finish;
   end

endmodule

// File: doc/conv3x3_channel_mac.md
# conv3x3_channel_mac

Downstream consumer of the convolution line buffer: accepts 3-row column vectors one channel per beat, keeps a per-channel 3-column sliding history, and forms the full 3x3 window. It multiplies the window by stored kernel weights and accumulates the result across all D input channels. One output pixel is emitted per spatial column position, once a complete 3-column window exists.

## Interface
- D, 1: number of input channels per spatial column
- DataWidth, 16: signed width of pixel and weight samples
- AccWidth, 2*DataWidth+$clog2(9*D): signed accumulator/output width
- i_clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-high
- i_w_data  in  DataWidth  signed kernel weight
- i_w_valid  in  1  weight beat valid; accepted only in LOAD_W
- i_col_data  in  3*DataWidth  column sample: [0+:DW]=top row, [DW+:DW]=middle row, [2DW+:DW]=bottom row
- i_col_valid  in  1  column beat valid
- o_col_ready  out  1  column beat accepted when i_col_valid && o_col_ready
- i_row_end  in  1  qualifies the accepted beat as the last beat of a row; meaningful only on channel D-1
- o_data  out  AccWidth  signed convolution result
- o_valid  out  1  single-cycle result strobe; no backpressure

## Operation
- FSM states: LOAD_W, RUN. Reset enters LOAD_W. Weights are reloaded only through reset.
- LOAD_W: o_col_ready=0. Each i_w_valid beat writes weight index w_cnt, then w_cnt increments. Index = c*9 + r*3 + k, where r=row 0..2 and k=column age (0 = two columns ago, 1 = previous, 2 = current). On the beat with w_cnt==9*D-1: go to RUN, o_col_ready=1 from the next cycle.
- RUN: o_col_ready=1 constantly. i_w_valid is ignored.
- Counters: ch_cnt is 0..D-1 and wraps after D-1. col_cnt saturates at 2 and counts completed spatial columns in the current row.
- Per accepted beat, for channel ch_cnt:
  - window = {hist1[ch], hist0[ch], current}.
  - The 9 signed products are summed into the running accumulator. The sum restarts on ch_cnt==0.
  - Then hist1[ch] <= hist0[ch] and hist0[ch] <= current.
- On the beat with ch_cnt==D-1:
  - If col_cnt==2, the accumulated sum is issued as a result.
  - Otherwise col_cnt increments.
- i_row_end on the ch_cnt==D-1 beat:
  - col_cnt <= 0 after that beat's result decision.
  - History is treated as invalid; it is not cleared, because col_cnt gating makes it unused.
- i_row_end on any other channel beat is ignored.
- Arithmetic: products are 2*DataWidth signed. The sum is sign-extended to AccWidth and cannot overflow by construction.
- Reset mid-row or mid-accumulation:
  - Any partial sum is discarded and no o_valid is produced.
  - All counters are zeroed and the FSM returns to LOAD_W.

## Timing
- Reset values: o_valid=0, o_data=0, o_col_ready=0, w_cnt=0, ch_cnt=0, col_cnt=0.
- Pipeline:
  - Stage 1 registers the 9 products and a "last" flag.
  - Stage 2 adds the product sum to the accumulator.
  - Stage 3 registers o_data/o_valid.
- Latency: o_valid rises 3 cycles after the accepting edge of the ch_cnt==D-1 beat.
- Throughput: 1 beat per cycle, with no bubbles between channels, columns or rows.
- o_data holds its last value when o_valid=0.
- Back-to-back beats for the same channel in consecutive cycles must read the updated history. History writes therefore happen at the accepting edge, and the next beat's read uses registered state.

## Configuration
- CONV_RELU_EN:
  - When defined, the stage-3 output is clamped, so negative results produce o_data=0.
  - When undefined, the signed sum passes unchanged.
  - Latency is identical either way.

## Structure
- Shared package conv_pkg:
  - FSM enum type: LOAD_W, RUN.
  - Function for AccWidth derivation.
  - Weight index helper (c*9 + r*3 + k).
- Sub-module mac9:
  - Combinational 9-way signed multiply plus adder tree, with one register stage.
  - Instantiated once.
  - Reusable by later stages that process multiple channels per beat.

## Test plan
- Reset, then idle 5 cycles -> o_valid=0, o_col_ready=0, o_data=0. 9*D weight beats are then required before o_col_ready=1.
- D=1, all weights 1; feed columns (1,1,1), (2,2,2), (3,3,3), (4,4,4) -> o_valid twice, o_data=18 then 27. The first strobe is 3 cycles after the third column beat.
- D=2, channel 0 weights all +1, channel 1 weights all -1, identical data on both channels -> every output is 0. Outputs occur only on channel-1 beats.
- D=1, i_row_end on the 3rd column, then 2 new columns -> no output until the 3rd column of the new row. The first new output uses only new-row data.
- Single channel with weights giving sum -7 -> o_data=0 with CONV_RELU_EN, and o_data = -7 sign-extended without it.
- Reset asserted between channel beats of a column (D=3, after ch 1) -> no o_valid follows. FSM is back in LOAD_W with o_col_ready=0.
